// File: rtl/lbist_pkg.sv
// Shared LBIST definitions: controller states and the per-width polynomial
// tap table used by both the pattern generator and the response MISR.
package lbist_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      CHECK = 2'd2,
      DONE  = 2'd3
   } state_e;

   localparam int unsigned MIN_WIDTH = 3;
   localparam int unsigned MAX_WIDTH = 30;

   // Tap mask for a maximal-length XOR polynomial of the given width.
   // Bit t of the result is set when stage t feeds the XOR; bit positions
   // match the 1-based stage numbering of the registers.
   function automatic logic [MAX_WIDTH:1] tap_mask(input int unsigned width);
      logic [MAX_WIDTH:1] m;
      m = '0;
      case (width)
         3:  begin m[3]  = 1'b1; m[2]  = 1'b1; end
         4:  begin m[4]  = 1'b1; m[3]  = 1'b1; end
         5:  begin m[5]  = 1'b1; m[3]  = 1'b1; end
         6:  begin m[6]  = 1'b1; m[5]  = 1'b1; end
         7:  begin m[7]  = 1'b1; m[6]  = 1'b1; end
         8:  begin m[8]  = 1'b1; m[6]  = 1'b1; m[5] = 1'b1; m[4] = 1'b1; end
         9:  begin m[9]  = 1'b1; m[5]  = 1'b1; end
         10: begin m[10] = 1'b1; m[7]  = 1'b1; end
         11: begin m[11] = 1'b1; m[9]  = 1'b1; end
         12: begin m[12] = 1'b1; m[6]  = 1'b1; m[4] = 1'b1; m[1] = 1'b1; end
         13: begin m[13] = 1'b1; m[4]  = 1'b1; m[3] = 1'b1; m[1] = 1'b1; end
         14: begin m[14] = 1'b1; m[5]  = 1'b1; m[3] = 1'b1; m[1] = 1'b1; end
         15: begin m[15] = 1'b1; m[14] = 1'b1; end
         16: begin m[16] = 1'b1; m[15] = 1'b1; m[13] = 1'b1; m[4] = 1'b1; end
         17: begin m[17] = 1'b1; m[14] = 1'b1; end
         18: begin m[18] = 1'b1; m[11] = 1'b1; end
         19: begin m[19] = 1'b1; m[6]  = 1'b1; m[2] = 1'b1; m[1] = 1'b1; end
         20: begin m[20] = 1'b1; m[17] = 1'b1; end
         21: begin m[21] = 1'b1; m[19] = 1'b1; end
         22: begin m[22] = 1'b1; m[21] = 1'b1; end
         23: begin m[23] = 1'b1; m[18] = 1'b1; end
         24: begin m[24] = 1'b1; m[23] = 1'b1; m[22] = 1'b1; m[17] = 1'b1; end
         25: begin m[25] = 1'b1; m[22] = 1'b1; end
         26: begin m[26] = 1'b1; m[6]  = 1'b1; m[2] = 1'b1; m[1] = 1'b1; end
         27: begin m[27] = 1'b1; m[5]  = 1'b1; m[2] = 1'b1; m[1] = 1'b1; end
         28: begin m[28] = 1'b1; m[25] = 1'b1; end
         29: begin m[29] = 1'b1; m[27] = 1'b1; end
         30: begin m[30] = 1'b1; m[6]  = 1'b1; m[4] = 1'b1; m[1] = 1'b1; end
         default: m = '0;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/lbist_misr_ctrl_misr_core.sv
// Multiple-input signature register: XOR-feedback shift register that
// folds one response word per enabled cycle into the running signature.
module misr_core
   import lbist_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           clear,
   input  logic           enable,
   input  logic [1:WIDTH] resp,
   output logic [1:WIDTH] sig
);

   localparam logic [MAX_WIDTH:1] TAPS = tap_mask(WIDTH);

   logic [1:WIDTH] sig_q;
   logic [1:WIDTH] sig_d;
   logic           fb;

   // Feedback bit: XOR of the signature stages selected by the tap mask.
   always_comb begin
      fb = 1'b0;
      for (int unsigned t = 1; t <= WIDTH; t++) begin
         if (TAPS[t]) begin
            fb = fb ^ sig_q[t];
         end
      end
   end

   // Next signature: clear wins, then compaction, otherwise hold.
   always_comb begin
      sig_d = sig_q;
      if (clear) begin
         sig_d = '0;
      end else if (enable) begin
         sig_d[1] = fb ^ resp[1];
         for (int unsigned i = 2; i <= WIDTH; i++) begin
            sig_d[i] = sig_q[i-1] ^ resp[i];
         end
      end
   end

   // Signature register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sig_q <= '0;
      end else begin
         sig_q <= sig_d;
      end
   end

   assign sig = sig_q;

endmodule

// File: rtl/lbist_misr_ctrl.sv
// LBIST response-compaction controller: sequences a run of num_patterns
// captures into the MISR, compares the final signature with the golden
// value and reports done/pass, while enabling the upstream generator.
module lbist_misr_ctrl
   import lbist_pkg::*;
#(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             abort,
   input  logic [CNT_W-1:0] num_patterns,
   input  logic             resp_valid,
   input  logic [1:WIDTH]   resp,
   input  logic [1:WIDTH]   golden,
   output logic             pattern_en,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [1:WIDTH]   signature
);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             pass_q, pass_d;
   logic             sig_clear;
   logic             sig_en;

   misr_core #(
      .WIDTH (WIDTH)
   ) u_misr (
      .clk    (clk),
      .rst_n  (reset_n),
      .clear  (sig_clear),
      .enable (sig_en),
      .resp   (resp),
      .sig    (signature)
   );

   // Next-state, counter and MISR control. Abort outranks start and
   // resp_valid; a start from DONE behaves exactly like one from IDLE.
   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      pass_d    = pass_q;
      sig_clear = 1'b0;
      sig_en    = 1'b0;
      unique case (state_q)
         IDLE, DONE: begin
            if (abort) begin
               state_d = IDLE;
               pass_d  = 1'b0;
            end else if (start) begin
               count_d   = num_patterns;
               sig_clear = 1'b1;
               pass_d    = 1'b0;
               state_d   = (num_patterns == '0) ? CHECK : RUN;
            end
         end
         RUN: begin
            if (abort) begin
               state_d = IDLE;
               pass_d  = 1'b0;
            end else if (resp_valid) begin
               sig_en  = 1'b1;
               count_d = count_q - CNT_ONE;
               if (count_q == CNT_ONE) begin
                  state_d = CHECK;
               end
            end
         end
         CHECK: begin
            if (abort) begin
               state_d = IDLE;
               pass_d  = 1'b0;
            end else begin
               pass_d  = (signature == golden);
               state_d = DONE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, pattern counter and compare-result registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         count_q <= '0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         pass_q  <= pass_d;
      end
   end

   assign pattern_en = (state_q == RUN);
   assign busy       = (state_q == RUN) || (state_q == CHECK);
   assign done       = (state_q == DONE);
   assign pass       = (state_q == DONE) && pass_q;

endmodule
